// File: rtl/cmos_fifo_wr_ctrl.sv
// cmos_fifo_wr_ctrl
// Packs CMOS pixel bytes (href-qualified, framed by vsync) into FIFO words.
// Bytes fill lanes low to high; a full word is written one cycle after its
// last byte. A short line is flushed zero-padded. A word that falls due while
// the FIFO is full is dropped, the sticky overflow flag is set, and the rest
// of the frame is discarded.
// Build option: define CMOS_FRAME_HEADER_EN to write the header word
// {16'hA5A5, frame_cnt} at the start of every frame.
//
// FIFO handshake: fifo_wr_en is a one-cycle write strobe carrying fifo_din.
// The FIFO's only back-pressure is fifo_full. It is sampled on the clock edge
// where a word falls due. When it is low, the strobe is issued in the
// following cycle. When it is high, no strobe is issued for that word.
module cmos_fifo_wr_ctrl #(
    parameter int PIX_W  = 8,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 24
) (
    input  logic              wr_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              fifo_full,
    input  logic              ovf_clr,
    output logic              fifo_wr_en,
    output logic [WORD_W-1:0] fifo_din,
    output logic              frame_done,
    output logic              overflow,
    output logic [15:0]       frame_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    localparam int NB  = WORD_W / PIX_W;
    localparam int K_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NB - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_FS = 3'd1,
        HEADER  = 3'd2,
        CAPTURE = 3'd3,
        FLUSH   = 3'd4,
        DROP    = 3'd5
    } state_t;

    state_t             state;
    logic               vsync_q;
    logic               href_q;
    logic [K_W-1:0]     k;
    logic [WORD_W-1:0]  word_buf;
    logic               end_pend;

    logic vsync_rise;
    logic vsync_fall;
    logic href_fall;

    // Edge detection against the once-registered sync inputs.
    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign href_fall  = ~href & href_q;

    // State is exposed directly for observation.
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Word counter increments until it reaches all-ones, then stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Capture FSM with registered write strobe, data, status and counters.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            k          <= '0;
            word_buf   <= '0;
            end_pend   <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
            word_cnt   <= '0;
        end else begin
            vsync_q    <= vsync;
            href_q     <= href;
            fifo_wr_en <= 1'b0;
            frame_done <= 1'b0;
            // A set further down in the same cycle overrides this clear.
            if (ovf_clr) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_FS;
                    end
                end

                WAIT_FS: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (vsync_fall) begin
                        word_cnt <= '0;
                        k        <= '0;
                        word_buf <= '0;
                        end_pend <= 1'b0;
`ifdef CMOS_FRAME_HEADER_EN
                        state    <= HEADER;
`else
                        state    <= CAPTURE;
`endif
                    end
                end

                HEADER: begin
                    if (fifo_full) begin
                        overflow <= 1'b1;
                        state    <= DROP;
                    end else begin
                        fifo_wr_en <= 1'b1;
                        fifo_din   <= WORD_W'({16'hA5A5, frame_cnt});
                        word_cnt   <= sat_inc(word_cnt);
                        state      <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (vsync_rise) begin
                        // The frame ends here. Any partial word goes out first through FLUSH.
                        if (k != '0) begin
                            end_pend <= 1'b1;
                            state    <= FLUSH;
                        end else begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            state      <= enable ? WAIT_FS : IDLE;
                        end
                    end else if (href) begin
                        if (k == K_LAST) begin
                            k        <= '0;
                            word_buf <= '0;
                            if (fifo_full) begin
                                overflow <= 1'b1;
                                state    <= DROP;
                            end else begin
                                fifo_wr_en <= 1'b1;
                                fifo_din   <= {pix_data, word_buf[WORD_W-PIX_W-1:0]};
                                word_cnt   <= sat_inc(word_cnt);
                            end
                        end else begin
                            for (int i = 0; i < NB; i++) begin
                                if (k == K_W'(i)) begin
                                    word_buf[i*PIX_W +: PIX_W] <= pix_data;
                                end
                            end
                            k <= k + K_W'(1);
                        end
                    end else if (href_fall && (k != '0)) begin
                        state <= FLUSH;
                    end
                end

                FLUSH: begin
                    // Unfilled upper lanes of word_buf are already zero.
                    k        <= '0;
                    word_buf <= '0;
                    end_pend <= 1'b0;
                    if (fifo_full) begin
                        overflow <= 1'b1;
                        if (end_pend || vsync_rise) begin
                            frame_done <= 1'b1;
                            state      <= enable ? WAIT_FS : IDLE;
                        end else begin
                            state <= DROP;
                        end
                    end else begin
                        fifo_wr_en <= 1'b1;
                        fifo_din   <= word_buf;
                        word_cnt   <= sat_inc(word_cnt);
                        if (end_pend || vsync_rise) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            state      <= enable ? WAIT_FS : IDLE;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end

                DROP: begin
                    // A dropped frame ends without being counted as completed.
                    k        <= '0;
                    word_buf <= '0;
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        state      <= enable ? WAIT_FS : IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cmos_fifo_wr_ctrl.md
CMOS_FIFO_WR_CTRL -- requirements
Module: cmos_fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning the CMOS pixel byte width.
REQ-002 SHALL have parameter WORD_W, default 32, meaning the FIFO word width; WORD_W/PIX_W = 4 bytes per word.
REQ-003 SHALL have parameter CNT_W, default 24, meaning the word_cnt width.
REQ-004 SHALL have port wr_clk, input, 1 bit: pixel clock and sole clock of the block.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low; the clock is wr_clk.
REQ-006 SHALL have port enable, input, 1 bit: capture arm.
REQ-007 SHALL have port vsync, input, 1 bit: frame sync, high = vertical blanking.
REQ-008 SHALL have port href, input, 1 bit: line valid, high = pixel byte valid.
REQ-009 SHALL have port pix_data, input, PIX_W bits: pixel byte.
REQ-010 SHALL have port fifo_full, input, 1 bit: FIFO full flag, wr_clk domain.
REQ-011 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-012 SHALL have port fifo_wr_en, output, 1 bit: FIFO write strobe.
REQ-013 SHALL have port fifo_din, output, WORD_W bits: FIFO write data.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-015 SHALL have port overflow, output, 1 bit: sticky overflow flag.
REQ-016 SHALL have port frame_cnt, output, 16 bits: count of completed frames.
REQ-017 SHALL have port word_cnt, output, CNT_W bits: words written in the current frame.
REQ-018 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, WAIT_FS, HEADER, CAPTURE, FLUSH and DROP.
REQ-020 IDLE->WAIT_FS when enable=1; WAIT_FS->CAPTURE on vsync falling edge (HEADER first when the macro of REQ-034 is defined).
REQ-021 CAPTURE: each cycle with href=1 SHALL sample pix_data into byte lane k (first byte in bits [PIX_W-1:0]), k = 0..3, k wrapping 3->0.
REQ-022 On the cycle the lane-3 byte is sampled, the next cycle SHALL drive fifo_wr_en=1 with the packed word on fifo_din (1-cycle latency; fifo_wr_en is never high for two words of the same byte group).
REQ-023 On href falling edge with k!=0, SHALL enter FLUSH, write the partial word zero-padded in the unfilled upper lanes, reset k=0, and return to CAPTURE (FLUSH lasts exactly 1 cycle).
REQ-024 SHALL never assert fifo_wr_en while fifo_full=1; a word that becomes due while fifo_full=1 SHALL be discarded, overflow SHALL be set, and the state SHALL go to DROP.
REQ-025 DROP SHALL ignore href/pix_data until vsync rises, then pulse frame_done and go to WAIT_FS (or IDLE if enable=0).
REQ-026 A vsync rising edge in CAPTURE SHALL end the frame: any partial word is flushed first (REQ-023 rules), frame_done pulses 1 cycle, frame_cnt increments (wrapping 0xFFFF->0), and the state goes to WAIT_FS if enable=1, else IDLE.
REQ-027 Deassertion of enable mid-frame SHALL NOT abort the frame; it takes effect at the frame end.
REQ-028 word_cnt SHALL clear to 0 on frame start, increment per fifo_wr_en, and saturate at all-ones.
REQ-029 ovf_clr=1 SHALL clear overflow; if a set condition occurs in the same cycle, set SHALL win.
REQ-030 vsync and href SHALL be registered once internally for edge detection.

Reset
REQ-031 On rst_n=0: state=IDLE, k=0, fifo_wr_en=0, fifo_din=0, frame_done=0, overflow=0, frame_cnt=0, word_cnt=0, busy=0.
REQ-032 Reset mid-frame SHALL discard the partial word without writing it; capture restarts only at the next vsync falling edge after rst_n=1 and enable=1.

Configuration
REQ-033 Without the macro of REQ-034, no header word is written; WAIT_FS goes straight to CAPTURE.
REQ-034 With CMOS_FRAME_HEADER_EN defined, HEADER (1 cycle) SHALL write {16'hA5A5, frame_cnt} before the first pixel word and count it in word_cnt; if fifo_full=1 in HEADER, REQ-024 applies.

Verification
REQ-035 enable=1, 1 line of 8 bytes 0x01..0x08, fifo_full=0 -> writes 0x04030201 then 0x08070605; word_cnt=2.
REQ-036 Line of 6 bytes 0x11..0x16 -> writes 0x14131211 then 0x00001615 via FLUSH.
REQ-037 fifo_full=1 when the 2nd word is due -> only 1 write, overflow=1, no writes until next frame; ovf_clr=1 -> overflow=0.
REQ-038 Two frames of 2 lines x 4 bytes -> 2 frame_done pulses, frame_cnt=2, word_cnt=2 per frame.
REQ-039 Header macro defined, frame_cnt=5 -> first write is 0xA5A50005.
REQ-040 rst_n pulsed low after 3 bytes of a line -> no write, all outputs at reset values, capture resumes at next frame start.
